// File: rtl/cpu_clk_ctrl_pkg.sv
// rtl/cpu_clk_ctrl_pkg.sv - shared run-mode encodings and step-FSM state type
package cpu_clk_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_FAST = 2'b00,
        MODE_SLOW = 2'b01,
        MODE_STEP = 2'b10,
        MODE_HALT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_PULSE    = 2'b01,
        S_WAIT_REL = 2'b10
    } step_state_e;

    // Debounce counter width; a single-cycle debounce still needs one bit.
    function automatic int db_cnt_width(input int db_cycles);
        return (db_cycles > 1) ? $clog2(db_cycles) : 1;
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// rtl/cpu_clk_ctrl_btn_debounce.sv - two-flop synchronizer plus stability-count debouncer
module btn_debounce
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = db_cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// rtl/cpu_clk_ctrl.sv - CPU advance-enable generator for fast/slow/single-step/halt modes
module cpu_clk_ctrl
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             div_fast,
    input  logic             div_slow,
    input  logic             btn_step,
    output logic             cpu_en,
    output logic [CNT_W-1:0] step_cnt,
    output logic             btn_db
);

    logic             db_level;
    logic             fast_q;
    logic             slow_q;
    logic [1:0]       mode_q;
    logic             btn_db_q;
    logic             db_prev_q;
    step_state_e      state_q;
    logic             cpu_en_q;
    logic [CNT_W-1:0] step_cnt_q;

    logic             mode_chg;
    logic             fast_rise;
    logic             slow_rise;
    logic             db_rise;
    logic             step_fire;
    logic             cpu_en_d;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_btn_debounce (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_step),
        .level(db_level)
    );

    assign mode_chg  = (mode != mode_q);
    assign fast_rise = div_fast & ~fast_q;
    assign slow_rise = div_slow & ~slow_q;
    assign db_rise   = btn_db_q & ~db_prev_q;
    assign step_fire = (state_q == S_IDLE) && db_rise && (mode == MODE_STEP);

    // A mode switch blanks the enable for its first cycle; edge history keeps tracking.
    always_comb begin
        cpu_en_d = 1'b0;
        if (!mode_chg) begin
            case (mode_q)
                MODE_FAST: cpu_en_d = fast_rise;
                MODE_SLOW: cpu_en_d = slow_rise;
                MODE_STEP: cpu_en_d = step_fire;
                default:   cpu_en_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fast_q     <= 1'b0;
            slow_q     <= 1'b0;
            mode_q     <= MODE_HALT;
            btn_db_q   <= 1'b0;
            db_prev_q  <= 1'b0;
            state_q    <= S_IDLE;
            cpu_en_q   <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            fast_q     <= div_fast;
            slow_q     <= div_slow;
            mode_q     <= mode;
            btn_db_q   <= db_level;
            db_prev_q  <= btn_db_q;
            cpu_en_q   <= cpu_en_d;
            step_cnt_q <= step_cnt_q + CNT_W'(cpu_en_d);
            // The step FSM finishes a started press even if mode leaves STEP.
            case (state_q)
                S_IDLE:     if (step_fire) state_q <= S_PULSE;
                S_PULSE:    state_q <= S_WAIT_REL;
                S_WAIT_REL: if (!btn_db_q) state_q <= S_IDLE;
                default:    state_q <= S_IDLE;
            endcase
        end
    end

    assign cpu_en   = cpu_en_q;
    assign step_cnt = step_cnt_q;
    assign btn_db   = btn_db_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb/tb_cpu_clk_ctrl.sv - scoreboard bench for cpu_clk_ctrl with DB_CYCLES=4, CNT_W=4
module tb_cpu_clk_ctrl;
    import cpu_clk_ctrl_pkg::*;

    localparam int DB  = 4;
    localparam int CNW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     mode;
    logic           div_fast;
    logic           div_slow;
    logic           btn_step;
    logic           cpu_en;
    logic [CNW-1:0] step_cnt;
    logic           btn_db;

    cpu_clk_ctrl #(
        .DB_CYCLES(DB),
        .CNT_W    (CNW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .div_fast(div_fast),
        .div_slow(div_slow),
        .btn_step(btn_step),
        .cpu_en  (cpu_en),
        .step_cnt(step_cnt),
        .btn_db  (btn_db)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   exp_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && cpu_en) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse_cycle", cyc, -1);
                end else begin
                    e = sb.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_step_cnt", int'(step_cnt), e.cnt);
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_pulse(input int at);
        exp_t e;
        exp_cnt = (exp_cnt + 1) % (1 << CNW);
        e.cyc   = at;
        e.cnt   = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_cpu_en", int'(cpu_en), 0);
        check("rst_step_cnt", int'(step_cnt), 0);
        check("rst_btn_db", int'(btn_db), 0);
        tick(2);
        rst     = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic press(input int hold);
        int n;
        btn_step = 1'b1;
        n = cyc;
        expect_pulse(n + 8);
        tick(hold);
        btn_step = 1'b0;
        tick(10);
    endtask

    initial begin
        int n;
        rst      = 1'b0;
        mode     = MODE_HALT;
        div_fast = 1'b0;
        div_slow = 1'b0;
        btn_step = 1'b0;
        #1;
        fork
            monitor();
        join_none

        // FAST: 8 rising edges of div_fast over 64 cycles
        do_reset();
        mode = MODE_FAST;
        tick(2);
        for (int i = 0; i < 64; i++) begin
            div_fast = ((i % 8) >= 4);
            if ((i % 8) == 4) expect_pulse(cyc + 1);
            tick(1);
        end
        div_fast = 1'b0;
        tick(3);
        check("fast_step_cnt", int'(step_cnt), 8);
        check("fast_sb_empty", sb.size(), 0);

        // STEP: bouncing press, single pulse
        do_reset();
        mode = MODE_STEP;
        tick(2);
        btn_step = 1'b1; tick(1);
        btn_step = 1'b0; tick(1);
        btn_step = 1'b1;
        n = cyc;
        expect_pulse(n + 8);
        tick(6);
        check("step_db_before", int'(btn_db), 0);
        tick(1);
        check("step_db_after", int'(btn_db), 1);
        tick(13);
        btn_step = 1'b0;
        tick(12);
        check("step_btn_db_released", int'(btn_db), 0);
        check("step_step_cnt", int'(step_cnt), 1);
        check("step_sb_empty", sb.size(), 0);

        // FAST->SLOW switch coinciding with div_slow rise is blanked
        do_reset();
        mode = MODE_FAST;
        tick(3);
        mode     = MODE_SLOW;
        div_slow = 1'b1;
        tick(5);
        div_slow = 1'b0;
        tick(3);
        div_slow = 1'b1;
        expect_pulse(cyc + 1);
        tick(4);
        check("switch_step_cnt", int'(step_cnt), 1);
        check("switch_sb_empty", sb.size(), 0);

        // HALT: no enables, debounce still tracks; a rise outside STEP never fires later
        do_reset();
        mode     = MODE_HALT;
        btn_step = 1'b1;
        n = cyc;
        for (int i = 0; i < 16; i++) begin
            div_fast = ((i % 4) >= 2);
            tick(1);
            if (cyc == n + 6) check("halt_db_before", int'(btn_db), 0);
            if (cyc == n + 7) check("halt_db_after", int'(btn_db), 1);
        end
        div_fast = 1'b0;
        check("halt_step_cnt", int'(step_cnt), 0);
        mode = MODE_STEP;
        tick(6);
        check("late_step_cnt", int'(step_cnt), 0);
        btn_step = 1'b0;
        tick(10);
        press(10);
        check("repress_step_cnt", int'(step_cnt), 1);
        check("halt_sb_empty", sb.size(), 0);

        // 17 presses: counter wraps 15 -> 0 -> 1
        do_reset();
        mode = MODE_STEP;
        tick(2);
        for (int i = 0; i < 17; i++) press(10);
        check("wrap_step_cnt", int'(step_cnt), 1);
        check("wrap_sb_empty", sb.size(), 0);

        // Reset while waiting for release with button held
        do_reset();
        mode = MODE_STEP;
        tick(2);
        btn_step = 1'b1;
        n = cyc;
        expect_pulse(n + 8);
        tick(12);
        check("midrst_cnt_before", int'(step_cnt), 1);
        do_reset();
        n = cyc;
        expect_pulse(n + 8);
        tick(6);
        check("midrst_db_before", int'(btn_db), 0);
        tick(1);
        check("midrst_db_after", int'(btn_db), 1);
        tick(5);
        btn_step = 1'b0;
        tick(12);
        check("midrst_step_cnt", int'(step_cnt), 1);
        check("midrst_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 1_000_000, is the number of consecutive stable clk samples needed to accept a button level change.
REQ-002 Parameter CNT_W, default 16, is the width of step_cnt.
REQ-003 Port clk  input  1  system clock; the divider runs on the same clock.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port mode  input  2  run mode, synchronous to clk: 00 FAST, 01 SLOW, 10 STEP, 11 HALT.
REQ-006 Port div_fast  input  1  fast divided-clock level from the divider, synchronous to clk.
REQ-007 Port div_slow  input  1  slow divided-clock level from the divider, synchronous to clk.
REQ-008 Port btn_step  input  1  raw, asynchronous, bouncing single-step push button, active-high.
REQ-009 Port cpu_en  output  1  one-clk-wide CPU advance enable.
REQ-010 Port step_cnt  output  CNT_W  count of cpu_en pulses issued.
REQ-011 Port btn_db  output  1  debounced button level.

Function
REQ-012 The block SHALL register div_fast, div_slow and mode every cycle, in all modes.
REQ-013 FAST: cpu_en SHALL be 1 for exactly one cycle, in the cycle after the clk edge that samples div_fast=1 following a sample of 0.
REQ-014 SLOW: same rule as REQ-013, applied to div_slow.
REQ-015 HALT: cpu_en SHALL stay 0.
REQ-016 Mode change: cpu_en SHALL be 0 in the cycle where mode differs from registered mode; edge history is unaffected, so no spurious pulse follows the change.
REQ-017 btn_step SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-018 Debounce counter:
- clears whenever the synchronized level equals btn_db;
- otherwise increments;
- on reaching DB_CYCLES-1, btn_db takes the synchronized level and the counter clears.
REQ-019 Latency: btn_db SHALL change exactly 2+DB_CYCLES cycles after the first clk edge that samples the new raw level, provided the raw level stays stable.
REQ-020 Step FSM states:
- S_IDLE: go to S_PULSE when btn_db rises and mode==STEP.
- S_PULSE: cpu_en=1 for one cycle, then go to S_WAIT_REL.
- S_WAIT_REL: go to S_IDLE when btn_db==0.
REQ-021 In STEP mode, cpu_en SHALL come only from S_PULSE, exactly 1 cycle after btn_db rises; one press gives exactly one pulse.
REQ-022 If mode leaves STEP while in S_PULSE or S_WAIT_REL, the FSM SHALL finish the pulse or wait for release, then go to S_IDLE; the pulse in S_PULSE is suppressed if REQ-016 applies.
REQ-023 step_cnt SHALL increment by 1 on each cycle with cpu_en=1 and wrap from 2^CNT_W-1 to 0.
REQ-024 A button rise while mode!=STEP SHALL NOT produce a pulse, including after a later switch to STEP; a new press is required.

Reset
REQ-025 On rst, all of the following SHALL clear immediately and asynchronously:
- cpu_en=0, step_cnt=0, btn_db=0;
- synchronizer flops, debounce counter and edge registers to 0;
- registered mode to 2'b11 (HALT);
- FSM to S_IDLE.
REQ-026 Reset mid-press: after rst releases, a held button SHALL produce btn_db=1 after 2+DB_CYCLES cycles and then exactly one step pulse if mode==STEP.

Structure
REQ-027 A shared package SHALL hold the mode encodings (MODE_FAST, MODE_SLOW, MODE_STEP, MODE_HALT) and the step-FSM state typedef.
REQ-028 The synchronizer and debouncer SHALL be one sub-module, btn_debounce, with parameter DB_CYCLES, inputs clk, rst, raw and output level.
REQ-029 The counter width SHALL be $clog2(DB_CYCLES), minimum 1 bit.

Verification (DB_CYCLES=4, CNT_W=4)
REQ-030 FAST, div_fast toggling with a period of 8 cycles for 64 cycles -> 8 single-cycle cpu_en pulses, each one cycle after a 0->1 sample; step_cnt=8.
REQ-031 STEP, btn_step bounces 1/0/1 at 1-cycle intervals, then holds 1 for 20 cycles and releases -> btn_db rises 6 cycles after the final rise; exactly one cpu_en pulse, 1 cycle after btn_db rises; step_cnt=1.
REQ-032 Mode switched FAST->SLOW on the same cycle div_slow first samples 1 -> no cpu_en in that cycle; the next div_slow rise pulses normally.
REQ-033 HALT with div_fast toggling and the button pressed -> cpu_en stays 0; btn_db still follows the button.
REQ-034 17 step presses -> step_cnt wraps 15->0 and reads 1 at the end.
REQ-035 rst asserted in S_WAIT_REL with the button still held -> all outputs 0 immediately; after release of rst, btn_db=1 at +6 cycles and one cpu_en pulse follows.
